// File: rtl/fpu_cmd_issuer_pkg.sv
// Shared types and constants for the fpu_top command issuer:
// op codes, issuer FSM states and the buffered command payload.
package fpu_cmd_issuer_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } issuer_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] din1;
    logic [DATA_W-1:0] din2;
    logic [OP_W-1:0]   op;
  } cmd_t;

endpackage

// File: rtl/fpu_cmd_issuer_if.sv
// Upstream command, fpu_top request/result and upstream response signals.
// master is the issuer side, slave is the surrounding system.
interface fpu_cmd_issuer_if;
  import fpu_cmd_issuer_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_din1;
  logic [DATA_W-1:0] cmd_din2;
  logic [OP_W-1:0]   cmd_op;

  logic [DATA_W-1:0] fpu_din1;
  logic [DATA_W-1:0] fpu_din2;
  logic [OP_W-1:0]   fpu_op_sel;
  logic              fpu_valid;
  logic [DATA_W-1:0] fpu_result;
  logic              fpu_ready;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [OP_W-1:0]   rsp_op;
  logic              rsp_timeout;
  logic              busy;

  modport master (
    input  cmd_valid,
    input  cmd_din1,
    input  cmd_din2,
    input  cmd_op,
    input  fpu_result,
    input  fpu_ready,
    input  rsp_ready,
    output cmd_ready,
    output fpu_din1,
    output fpu_din2,
    output fpu_op_sel,
    output fpu_valid,
    output rsp_valid,
    output rsp_result,
    output rsp_op,
    output rsp_timeout,
    output busy
  );

  modport slave (
    output cmd_valid,
    output cmd_din1,
    output cmd_din2,
    output cmd_op,
    output fpu_result,
    output fpu_ready,
    output rsp_ready,
    input  cmd_ready,
    input  fpu_din1,
    input  fpu_din2,
    input  fpu_op_sel,
    input  fpu_valid,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_op,
    input  rsp_timeout,
    input  busy
  );

endinterface

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO with wrap-bit pointers; also exposes the
// next-cycle full/empty so the owner can register its status outputs.
module fpu_cmd_fifo
  import fpu_cmd_issuer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  cmd_t wdata,
  output cmd_t rdata_c,
  output logic empty_c,
  output logic full_nxt_c,
  output logic empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr_nxt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Same index with opposite wrap bit means every slot is occupied.
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_c = (wr_ptr_q == rd_ptr_q);

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty_c;

  assign wr_ptr_nxt = wr_ptr_q + PW'(do_push);
  assign rd_ptr_nxt = rd_ptr_q + PW'(do_pop);

  assign full_nxt_c  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                       (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign empty_nxt_c = (wr_ptr_nxt == rd_ptr_nxt);

  assign rdata_c = mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_nxt;
      rd_ptr_q <= rd_ptr_nxt;
    end
  end

  // Storage needs no reset: pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/fpu_cmd_issuer.sv
// Buffers upstream FPU commands and issues them one at a time to fpu_top,
// returning each result (or a timeout abort) over a valid/ready response port.
module fpu_cmd_issuer
  import fpu_cmd_issuer_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  fpu_cmd_issuer_if.master  bus
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  issuer_state_t     state_q;
  issuer_state_t     state_d;

  logic              cmd_ready_q;
  logic              busy_q;
  logic [DATA_W-1:0] fpu_din1_q;
  logic [DATA_W-1:0] fpu_din2_q;
  logic [OP_W-1:0]   fpu_op_sel_q;
  logic              fpu_valid_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [OP_W-1:0]   rsp_op_q;
  logic              rsp_timeout_q;
  logic [TW-1:0]     timer_q;

  logic              fpu_valid_d;
  logic              rsp_valid_d;
  logic              load_cmd_c;
  logic              capture_c;
  logic              timer_expired_c;

  cmd_t              cmd_in;
  cmd_t              cmd_head_c;
  logic              fifo_push;
  logic              fifo_empty_c;
  logic              fifo_full_nxt_c;
  logic              fifo_empty_nxt_c;

  assign cmd_in.din1 = bus.cmd_din1;
  assign cmd_in.din2 = bus.cmd_din2;
  assign cmd_in.op   = bus.cmd_op;

  // cmd_ready is the registered !full, so a full FIFO refuses even on a pop cycle.
  assign fifo_push = bus.cmd_valid & cmd_ready_q;

  fpu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .pop         (load_cmd_c),
    .wdata       (cmd_in),
    .rdata_c     (cmd_head_c),
    .empty_c     (fifo_empty_c),
    .full_nxt_c  (fifo_full_nxt_c),
    .empty_nxt_c (fifo_empty_nxt_c)
  );

  assign timer_expired_c = (state_q == WAIT) && (timer_q == TW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty_c) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.fpu_ready || timer_expired_c) state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/control decode; valids are computed from the next state so they register with it.
  always_comb begin
    fpu_valid_d = 1'b0;
    rsp_valid_d = 1'b0;
    load_cmd_c  = 1'b0;
    capture_c   = 1'b0;
    if (state_d == ISSUE) fpu_valid_d = 1'b1;
    if (state_d == RESP)  rsp_valid_d = 1'b1;
    if ((state_q == IDLE) && !fifo_empty_c) load_cmd_c = 1'b1;
    if ((state_q == WAIT) && (bus.fpu_ready || timer_expired_c)) capture_c = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      fpu_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      cmd_ready_q <= ~fifo_full_nxt_c;
      busy_q      <= (state_d != IDLE) | ~fifo_empty_nxt_c;
      fpu_valid_q <= fpu_valid_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Operand registers double as the fpu_top request bus and hold between issues.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_din1_q   <= '0;
      fpu_din2_q   <= '0;
      fpu_op_sel_q <= '0;
    end else if (load_cmd_c) begin
      fpu_din1_q   <= cmd_head_c.din1;
      fpu_din2_q   <= cmd_head_c.din2;
      fpu_op_sel_q <= cmd_head_c.op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (state_q == ISSUE) begin
      timer_q <= '0;
    end else if (state_q == WAIT) begin
      timer_q <= timer_q + TW'(1);
    end
  end

  // A ready on the final timer cycle still counts as a normal completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_q  <= '0;
      rsp_op_q      <= '0;
      rsp_timeout_q <= 1'b0;
    end else if (capture_c) begin
      rsp_result_q  <= bus.fpu_ready ? bus.fpu_result : '0;
      rsp_op_q      <= fpu_op_sel_q;
      rsp_timeout_q <= ~bus.fpu_ready;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.busy        = busy_q;
  assign bus.fpu_din1    = fpu_din1_q;
  assign bus.fpu_din2    = fpu_din2_q;
  assign bus.fpu_op_sel  = fpu_op_sel_q;
  assign bus.fpu_valid   = fpu_valid_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_op      = rsp_op_q;
  assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_fpu_cmd_issuer.sv
// Directed bench for fpu_cmd_issuer; the bench plays both upstream and fpu_top.
module tb_fpu_cmd_issuer;
  import fpu_cmd_issuer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  fpu_cmd_issuer_if bus();

  fpu_cmd_issuer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 1+2=3, 3-1=2, 2*3=6, 3/2=1.5
  logic [31:0] tab_a   [4] = '{32'h3F800000, 32'h40400000, 32'h40000000, 32'h40400000};
  logic [31:0] tab_b   [4] = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h40000000};
  logic [1:0]  tab_op  [4] = '{OP_ADD, OP_SUB, OP_MUL, OP_DIV};
  logic [31:0] tab_res [4] = '{32'h40400000, 32'h40000000, 32'h40C00000, 32'h3FC00000};

  task automatic drive_cmd(input int idx);
    bus.cmd_valid = 1'b1;
    bus.cmd_din1  = tab_a[idx];
    bus.cmd_din2  = tab_b[idx];
    bus.cmd_op    = tab_op[idx];
  endtask

  task automatic push_cmd(input int idx);
    drive_cmd(idx);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL push_ready idx=%0d got=%b exp=1", idx, bus.cmd_ready);
    end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Optionally wait for the issue pulse, then answer with ready and accept the response.
  task automatic serve_op(input int idx, input bit need_issue);
    bit ok;
    if (need_issue) begin
      ok = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (bus.fpu_valid === 1'b1) begin ok = 1'b1; break; end
        @(negedge clk);
      end
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL issue_wait idx=%0d no fpu_valid", idx); end
      n_checks++;
      if ({bus.fpu_din1, bus.fpu_din2, bus.fpu_op_sel} !== {tab_a[idx], tab_b[idx], tab_op[idx]}) begin
        n_fail++; $display("FAIL issue_operands idx=%0d got=%h_%h_%0d exp=%h_%h_%0d", idx,
                           bus.fpu_din1, bus.fpu_din2, bus.fpu_op_sel, tab_a[idx], tab_b[idx], tab_op[idx]);
      end
      @(negedge clk);
      n_checks++;
      if (bus.fpu_valid !== 1'b0) begin n_fail++; $display("FAIL valid_pulse idx=%0d got=%b exp=0", idx, bus.fpu_valid); end
    end
    bus.fpu_ready  = 1'b1;
    bus.fpu_result = tab_res[idx];
    @(negedge clk);
    bus.fpu_ready  = 1'b0;
    bus.fpu_result = 32'h0;
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_op, bus.rsp_result} !== {1'b1, 1'b0, tab_op[idx], tab_res[idx]}) begin
      n_fail++; $display("FAIL rsp idx=%0d got v=%b to=%b op=%0d res=%h exp v=1 to=0 op=%0d res=%h", idx,
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_op, bus.rsp_result, tab_op[idx], tab_res[idx]);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_accept idx=%0d got=%b exp=0", idx, bus.rsp_valid); end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0; bus.cmd_din1 = '0; bus.cmd_din2 = '0; bus.cmd_op = '0;
    bus.fpu_ready = 1'b0; bus.fpu_result = '0; bus.rsp_ready = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.cmd_ready, bus.fpu_valid, bus.rsp_valid, bus.busy, bus.rsp_timeout} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=00000",
                         {bus.cmd_ready, bus.fpu_valid, bus.rsp_valid, bus.busy, bus.rsp_timeout});
    end
    n_checks++;
    if ({bus.fpu_din1, bus.fpu_din2, bus.rsp_result} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got=%h_%h_%h exp=0", bus.fpu_din1, bus.fpu_din2, bus.rsp_result);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release got=%b exp=0", bus.cmd_ready); end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_single_add();
    drive_cmd(0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    n_checks++;
    if ({bus.fpu_valid, bus.busy} !== 2'b01) begin
      n_fail++; $display("FAIL add_lat1 got valid/busy=%b exp=01", {bus.fpu_valid, bus.busy});
    end
    @(negedge clk);
    n_checks++;
    if (bus.fpu_valid !== 1'b1) begin n_fail++; $display("FAIL add_lat2 got=%b exp=1", bus.fpu_valid); end
    serve_op(0, 1'b1);
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_idle_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      drive_cmd(i % 4);
      n_checks++;
      if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, bus.cmd_ready); end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    n_checks++;
    if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full got=%b exp=0", bus.cmd_ready); end
    serve_op(0, 1'b0);
    for (int i = 1; i < 4; i++) serve_op(i, 1'b1);
    serve_op(0, 1'b1);
    n_checks++;
    if ({bus.busy, bus.cmd_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_drain got busy/ready=%b exp=01", {bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_backpressure();
    bit stable;
    push_cmd(2);
    @(negedge clk);
    @(negedge clk);
    bus.fpu_ready = 1'b1; bus.fpu_result = tab_res[2];
    @(negedge clk);
    bus.fpu_ready = 1'b0; bus.fpu_result = 32'hFFFFFFFF;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) drive_cmd(1);
      if (c == 4) bus.cmd_valid = 1'b0;
      if ({bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.fpu_valid} !== {1'b1, tab_res[2], OP_MUL, 1'b0})
        stable = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_hold got unstable rsp or extra issue exp=stable"); end
    n_checks++;
    if (bus.rsp_result !== 32'h40C00000) begin n_fail++; $display("FAIL bp_result got=%h exp=40c00000", bus.rsp_result); end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    serve_op(1, 1'b1);
  endtask

  task automatic test_timeout();
    int cycles;
    push_cmd(3);
    @(negedge clk);
    n_checks++;
    if (bus.fpu_valid !== 1'b1) begin n_fail++; $display("FAIL to_issue got=%b exp=1", bus.fpu_valid); end
    cycles = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      cycles++;
      if (bus.rsp_valid === 1'b1) break;
    end
    n_checks++;
    if (cycles != 65) begin n_fail++; $display("FAIL to_latency got=%0d exp=65", cycles); end
    n_checks++;
    if ({bus.rsp_valid, bus.rsp_timeout, bus.rsp_op, bus.rsp_result} !== {1'b1, 1'b1, OP_DIV, 32'h0}) begin
      n_fail++; $display("FAIL to_rsp got v=%b to=%b op=%0d res=%h exp v=1 to=1 op=3 res=0",
                         bus.rsp_valid, bus.rsp_timeout, bus.rsp_op, bus.rsp_result);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    push_cmd(0);
    serve_op(0, 1'b1);
    // Ready arriving on the last allowed WAIT cycle wins over the abort.
    push_cmd(2);
    @(negedge clk);
    repeat (64) @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL to_edge_early got=%b exp=0", bus.rsp_valid); end
    serve_op(2, 1'b0);
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) begin
      drive_cmd(i);
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus.cmd_ready, bus.fpu_valid, bus.rsp_valid, bus.busy, bus.fpu_op_sel, bus.fpu_din1} !== 38'h0) begin
      n_fail++; $display("FAIL midreset_async got rdy=%b v=%b rv=%b busy=%b op=%0d d1=%h exp all 0",
                         bus.cmd_ready, bus.fpu_valid, bus.rsp_valid, bus.busy, bus.fpu_op_sel, bus.fpu_din1);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.fpu_valid, bus.busy, bus.cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL midreset_after got rv/v/busy/rdy=%b exp=0001",
                         {bus.rsp_valid, bus.fpu_valid, bus.busy, bus.cmd_ready});
    end
  endtask

  task automatic test_stray_ready();
    bus.fpu_ready = 1'b1; bus.fpu_result = 32'hDEADBEEF;
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
      n_fail++; $display("FAIL stray_idle got rv/busy=%b exp=00", {bus.rsp_valid, bus.busy});
    end
    push_cmd(1);
    @(negedge clk);
    n_checks++;
    if (bus.fpu_valid !== 1'b1) begin n_fail++; $display("FAIL stray_issue got=%b exp=1", bus.fpu_valid); end
    bus.fpu_ready = 1'b1; bus.fpu_result = 32'hBAD0BAD0;
    @(negedge clk);
    bus.fpu_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_issue_ignored got=%b exp=0", bus.rsp_valid); end
    serve_op(1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_op();
    test_stray_ready();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
